// File: rtl/cnn_div_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIVIDEND_W / DIVISOR_W / QUOT_W : operand, remainder and quotient widths
//   QMAX / QMIN                     : saturation limits of the signed quotient
//   div_state_e                     : handshake FSM state encoding
package cnn_div_pkg;

  localparam int DIVIDEND_W = 20;
  localparam int DIVISOR_W  = 6;
  localparam int QUOT_W     = 14;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  localparam int QMAX = 8191;
  localparam int QMIN = -8192;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage : cnn_div_pkg

// File: rtl/cnn_div_core_u.sv
// Unsigned restoring divider iteration, one quotient bit per step, MSB first.
//   clk, rst_n   : clock, synchronous active-low reset
//   load_i       : capture dividend/divisor magnitudes and clear the iteration
//   step_i       : perform one restoring step
//   dividend_i   : unsigned dividend magnitude
//   divisor_i    : unsigned divisor magnitude
//   quot_o       : quotient magnitude (valid after DIVIDEND_W steps)
//   rem_o        : remainder magnitude (valid after DIVIDEND_W steps)
//   last_o       : high during the final step
module cnn_div_core_u
  import cnn_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic [DIVIDEND_W-1:0] quot_o,
  output logic [DIVISOR_W-1:0]  rem_o,
  output logic                  last_o
);

  logic [DIVISOR_W-1:0]  pr_q, pr_d;
  logic [DIVIDEND_W-1:0] sh_q, sh_d;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVISOR_W:0]    trial;
  logic                  ge;

  // The dividend shifts out of sh_q's MSB while quotient bits shift into its
  // LSB, so after DIVIDEND_W steps sh_q holds the quotient.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pr_d  = pr_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    trial = {pr_q, sh_q[DIVIDEND_W-1]};
    ge    = (trial >= {1'b0, dvs_q});
    if (step_i) begin
      pr_d  = ge ? DIVISOR_W'(trial - {1'b0, dvs_q}) : trial[DIVISOR_W-1:0];
      sh_d  = {sh_q[DIVIDEND_W-2:0], ge};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block ordering.
    if (!rst_n) begin
      pr_q  <= '0;
      sh_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      pr_q  <= '0;
      sh_q  <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else begin
      pr_q  <= pr_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign quot_o = sh_q;
  assign rem_o  = pr_q;
  assign last_o = step_i && (cnt_q == CNT_W'(DIVIDEND_W - 1));

endmodule : cnn_div_core_u

// File: rtl/cnn_sdiv_20s_6s_seq.sv
// Sequential signed divider: 20-bit signed dividend by 6-bit signed divisor,
// 14-bit saturating signed quotient and 6-bit signed remainder.
//   ap_clk, ap_rst_n          : clock, synchronous active-low reset
//   ap_start/ap_ready         : request; ready pulses when operands are captured
//   ap_idle/ap_done           : idle level; done pulses when results are valid
//   din0, din1                : dividend, divisor (signed)
//   quot, rem                 : quotient (truncated toward zero), remainder
//   ovf, dbz                  : quotient saturated, divide by zero
// Results and flags are held until the next completed operation.
module cnn_sdiv_20s_6s_seq
  import cnn_div_pkg::*;
(
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic signed [DIVIDEND_W-1:0] din0,
  input  logic signed [DIVISOR_W-1:0]  din1,
  output logic signed [QUOT_W-1:0]     quot,
  output logic signed [DIVISOR_W-1:0]  rem,
  output logic                         ovf,
  output logic                         dbz
);

  div_state_e state_q;
  logic       sign_n_q, sign_d_q, zero_q;

  logic [DIVIDEND_W-1:0] dvd_mag, core_quot;
  logic [DIVISOR_W-1:0]  dvs_mag, core_rem;
  logic                  core_last;

  logic signed [QUOT_W-1:0]    quot_d;
  logic signed [DIVISOR_W-1:0] rem_d;
  logic                        ovf_d;

  assign ap_idle  = (state_q == S_IDLE);
  assign ap_ready = ap_idle && ap_start;
  assign ap_done  = (state_q == S_DONE);

  // Magnitudes are unsigned, so -(-2^19) = 2^19 fits the 20-bit field.
  assign dvd_mag = din0[DIVIDEND_W-1] ? DIVIDEND_W'(-din0) : DIVIDEND_W'(din0);
  assign dvs_mag = din1[DIVISOR_W-1]  ? DIVISOR_W'(-din1)  : DIVISOR_W'(din1);

  cnn_div_core_u u_core (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .load_i     (ap_ready),
    .step_i     (state_q == S_CALC),
    .dividend_i (dvd_mag),
    .divisor_i  (dvs_mag),
    .quot_o     (core_quot),
    .rem_o      (core_rem),
    .last_o     (core_last)
  );

  // Sign application and saturation. A negative quotient may reach one more
  // magnitude step than a positive one.
  always_comb begin
    quot_d = '0;
    ovf_d  = 1'b0;
    rem_d  = sign_n_q ? DIVISOR_W'(-core_rem) : core_rem;
    if (zero_q) begin
      quot_d = sign_n_q ? QUOT_W'(QMIN) : QUOT_W'(QMAX);
      rem_d  = '0;
    end else if (!(sign_n_q ^ sign_d_q)) begin
      if (core_quot > DIVIDEND_W'(QMAX)) begin
        quot_d = QUOT_W'(QMAX);
        ovf_d  = 1'b1;
      end else begin
        quot_d = core_quot[QUOT_W-1:0];
      end
    end else begin
      if (core_quot > DIVIDEND_W'(-QMIN)) begin
        quot_d = QUOT_W'(QMIN);
        ovf_d  = 1'b1;
      end else begin
        quot_d = QUOT_W'(-core_quot[QUOT_W-1:0]);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      sign_n_q <= 1'b0;
      sign_d_q <= 1'b0;
      zero_q   <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      ovf      <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            sign_n_q <= din0[DIVIDEND_W-1];
            sign_d_q <= din1[DIVISOR_W-1];
            zero_q   <= (din1 == '0);
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          if (core_last) state_q <= S_FIX;
        end
        S_FIX: begin
          quot    <= quot_d;
          rem     <= rem_d;
          ovf     <= ovf_d;
          dbz     <= zero_q;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule : cnn_sdiv_20s_6s_seq

// File: tb/tb_cnn_sdiv_20s_6s_seq.sv
module tb_cnn_sdiv_20s_6s_seq;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               ap_start = 1'b0;
  logic               ap_ready, ap_idle, ap_done;
  logic signed [19:0] din0 = '0;
  logic signed [5:0]  din1 = '0;
  logic signed [13:0] quot;
  logic signed [5:0]  rem;
  logic               ovf, dbz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_sdiv_20s_6s_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .quot     (quot),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  typedef struct {
    logic signed [19:0] a;
    logic signed [5:0]  b;
    int                 q;
    int                 r;
    logic               ovf;
    logic               dbz;
  } vec_t;

  vec_t vecs[16];
  vec_t b2b[3];

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first CALC cycle.
  task automatic start_op(input logic signed [19:0] a, input logic signed [5:0] b);
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    @(negedge ap_clk);
    check("ap_ready_on_start", ap_ready, 1);
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    din0 = 20'($urandom);
    din1 = 6'($urandom);
  endtask

  // Returns the cycle index (ready cycle = 0) in which ap_done is seen, or -1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        lat = k;
        break;
      end
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start_op(v.a, v.b);
    check($sformatf("busy_not_idle[%0d]", idx), ap_idle, 0);
    wait_done(lat);
    check($sformatf("latency[%0d]", idx), lat, 22);
    check($sformatf("quot[%0d]", idx), quot, v.q);
    check($sformatf("rem[%0d]", idx), rem, v.r);
    check($sformatf("ovf[%0d]", idx), ovf, v.ovf);
    check($sformatf("dbz[%0d]", idx), dbz, v.dbz);
    @(posedge ap_clk);
    #1;
    check($sformatf("done_pulse[%0d]", idx), ap_done, 0);
    check($sformatf("idle_after[%0d]", idx), ap_idle, 1);
  endtask

  initial begin
    int rc[3];
    int dc[3];
    int nr, nd, lat;
    bit seen_done;

    vecs[0]  = '{20'sd1000,    6'sd7,   142,   6, 1'b0, 1'b0};
    vecs[1]  = '{-20'sd1000,   6'sd7,  -142,  -6, 1'b0, 1'b0};
    vecs[2]  = '{20'sd1000,   -6'sd7,  -142,   6, 1'b0, 1'b0};
    vecs[3]  = '{-20'sd1000,  -6'sd7,   142,  -6, 1'b0, 1'b0};
    vecs[4]  = '{-20'sd524288, -6'sd1, 8191,   0, 1'b1, 1'b0};
    vecs[5]  = '{20'sd524287, -6'sd32, -8192, 31, 1'b1, 1'b0};
    vecs[6]  = '{20'sd5,       6'sd0,  8191,   0, 1'b0, 1'b1};
    vecs[7]  = '{-20'sd5,      6'sd0, -8192,   0, 1'b0, 1'b1};
    vecs[8]  = '{20'sd57344,   6'sd7,  8191,   0, 1'b1, 1'b0};
    vecs[9]  = '{-20'sd57344,  6'sd7, -8192,   0, 1'b0, 1'b0};
    vecs[10] = '{20'sd57337,   6'sd7,  8191,   0, 1'b0, 1'b0};
    vecs[11] = '{-20'sd57351,  6'sd7, -8192,   0, 1'b1, 1'b0};
    vecs[12] = '{20'sd0,       6'sd5,     0,   0, 1'b0, 1'b0};
    vecs[13] = '{-20'sd3,      6'sd5,     0,  -3, 1'b0, 1'b0};
    vecs[14] = '{20'sd31,     -6'sd32,    0,  31, 1'b0, 1'b0};
    vecs[15] = '{-20'sd524288, -6'sd32, 8191,  0, 1'b1, 1'b0};

    b2b[0] = '{20'sd300,    -6'sd9,  -33,   3, 1'b0, 1'b0};
    b2b[1] = '{-20'sd7777,   6'sd13, -598, -3, 1'b0, 1'b0};
    b2b[2] = '{20'sd524287,  6'sd31, 8191, 15, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dbz", dbz, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back: ap_start held high, operands change while busy.
    foreach (rc[i]) begin
      rc[i] = -1;
      dc[i] = -1;
    end
    nr = 0;
    nd = 0;
    ap_start = 1'b1;
    for (int cyc = 0; cyc < 100 && nd < 3; cyc++) begin
      if (nr < 3) begin
        din0 = b2b[nr].a;
        din1 = b2b[nr].b;
      end else begin
        din0 = 20'($urandom);
        din1 = 6'($urandom);
      end
      @(negedge ap_clk);
      if (ap_ready && nr < 3) begin
        rc[nr] = cyc;
        nr++;
      end
      if (ap_done && nd < 3) begin
        dc[nd] = cyc;
        check($sformatf("b2b_quot[%0d]", nd), quot, b2b[nd].q);
        check($sformatf("b2b_rem[%0d]", nd), rem, b2b[nd].r);
        check($sformatf("b2b_ovf[%0d]", nd), ovf, b2b[nd].ovf);
        nd++;
      end
      @(posedge ap_clk);
      #1;
    end
    ap_start = 1'b0;
    check("b2b_done_count", nd, 3);
    check("b2b_ready_gap01", rc[1] - rc[0], 23);
    check("b2b_ready_gap12", rc[2] - rc[1], 23);
    foreach (rc[i]) check($sformatf("b2b_latency[%0d]", i), dc[i] - rc[i], 22);
    @(posedge ap_clk);
    #1;

    // Load nonzero held outputs, then reset in the middle of CALC.
    run_vec(vecs[7], 7);
    start_op(20'sd1000, 6'sd7);
    repeat (9) begin
      @(posedge ap_clk);
      #1;
    end
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    check("midrst_idle", ap_idle, 1);
    check("midrst_done", ap_done, 0);
    check("midrst_quot", quot, 0);
    check("midrst_rem", rem, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_dbz", dbz, 0);
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge ap_clk);
      if (ap_done) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 0);
    @(posedge ap_clk);
    #1;
    start_op(20'sd100, 6'sd3);
    wait_done(lat);
    check("post_rst_latency", lat, 22);
    check("post_rst_quot", quot, 33);
    check("post_rst_rem", rem, 1);
    check("post_rst_ovf", ovf, 0);
    check("post_rst_dbz", dbz, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_cnn_sdiv_20s_6s_seq

// File: doc/cnn_sdiv_20s_6s_seq.md
Name: cnn_sdiv_20s_6s_seq

Overview:
Sequential signed divider that inverts the 14s x 6s -> 20s DSP multiply used in the conv datapath. It recovers a 14-bit signed quotient and a 6-bit signed remainder from a 20-bit signed accumulator value and a 6-bit signed coefficient. It is used for requantization and rescaling between conv1 and the pooling stages. The control interface is an ap_start/ap_done/ap_idle/ap_ready block handshake, and the datapath computes one quotient bit per clock.

Parameters:
DIVIDEND_W, 20, dividend width (signed); only the default is verified
DIVISOR_W, 6, divisor and remainder width (signed)
QUOT_W, 14, quotient width (signed); outputs saturate to this range

Ports:
ap_clk  in  1  single clock; all logic is rising-edge
ap_rst_n  in  1  synchronous, active-low reset
ap_start  in  1  request; sampled only in IDLE
ap_ready  out  1  one-cycle pulse when operands are captured
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse when results are valid
din0  in  DIVIDEND_W  dividend (signed)
din1  in  DIVISOR_W  divisor (signed)
quot  out  QUOT_W  quotient (signed), held until the next ap_done
rem  out  DIVISOR_W  remainder (signed), held
ovf  out  1  quotient saturated; held
dbz  out  1  divide by zero; held

Behaviour:
- Reset (ap_rst_n=0 at a rising edge):
  - State goes to IDLE.
  - quot, rem, ovf, dbz, ap_done and ap_ready all become 0; ap_idle=1.
  - This applies mid-operation too: the operation is abandoned and no ap_done is produced.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: ap_idle=1. If ap_start=1, assert ap_ready combinationally in that cycle, capture din0/din1, and go to CALC at the edge.
  - CALC: runs for exactly DIVIDEND_W (20) cycles, then goes to FIX.
  - FIX: one cycle; applies signs and saturation, registers the outputs, then goes to DONE.
  - DONE: ap_done=1 for one cycle, then back to IDLE.
- Latency: capture edge at T0, ap_done high during cycle T0+22. Next start is accepted at T0+23 at the earliest, so throughput is one operation per 23 cycles.
- ap_start while busy is ignored; din0/din1 need not be held stable after ap_ready.
- Arithmetic in CALC:
  - Unsigned restoring division on magnitudes: 20-bit |dividend| (covers 2^19) and 6-bit |divisor| (covers 32).
  - Partial remainder is 7 bits; one quotient bit per cycle, MSB first.
- FIX stage:
  - Quotient sign = sign(din0) XOR sign(din1); quotient truncates toward zero.
  - Remainder takes the sign of din0, with magnitude < |din1|, so it always fits in 6 bits.
- Saturation:
  - Positive quotient magnitude > 8191 -> quot=8191, ovf=1.
  - Negative quotient magnitude > 8192 -> quot=-8192, ovf=1.
  - When ovf=1, rem holds the true remainder.
- Divide by zero (din1=0): dbz=1, ovf=0, rem=0; quot=8191 if din0>=0, else -8192. Latency is unchanged.
- Flags are overwritten on every ap_done.

Decomposition:
- Shared package cnn_div_pkg:
  - Width constants DIVIDEND_W, DIVISOR_W, QUOT_W.
  - QMAX=8191, QMIN=-8192.
  - FSM state enum (2-bit).
- Sub-module cnn_div_core_u: unsigned restoring iteration (partial remainder, quotient shift register, bit counter).
- Top level: handshake FSM plus sign/saturation logic.

Test Plan:
- din0=1000, din1=7 -> quot=142, rem=6, ovf=0, dbz=0; ap_done exactly 22 cycles after the ap_ready cycle.
- din0=-1000, din1=7 -> quot=-142, rem=-6. Also din0=1000, din1=-7 -> quot=-142, rem=6.
- din0=-524288, din1=-1 -> quot=8191, ovf=1, rem=0. Also din0=524287, din1=-32 -> quot=-8192, ovf=1, rem=31.
- din0=5, din1=0 -> quot=8191, dbz=1, rem=0. Also din0=-5, din1=0 -> quot=-8192, dbz=1.
- ap_start held high for 3 operations with changing din -> three ap_ready/ap_done pairs, 23 cycles apart; din changes while busy do not affect results.
- ap_rst_n=0 for one cycle at cycle 10 of CALC -> no ap_done, outputs 0, ap_idle=1 next cycle; the next operation (100/3 -> 33, rem 1) is correct.
